// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: walks the rows, classifies each full scan as
// none/single/multi, debounces scan results and strobes a one-hot digit.
module keypad_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [9:0] keypad,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } result_t;

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
    localparam logic [3:0] DEB_N    = 4'(DEBOUNCE);

    logic [2:0] col_meta_q;
    logic [2:0] col_sync_q;
    logic [7:0] div_q;
    logic [1:0] row_q;
    logic [3:0] row_n_q;
    logic [1:0] acc_cnt_q;
    logic [3:0] acc_key_q;
    state_t     state_q;
    logic [3:0] cand_q;
    logic [3:0] count_q;
    logic [9:0] keypad_q;
    logic       valid_q;
    logic       held_q;

    logic [2:0] row_low_s;
    logic [1:0] row_hits_s;
    logic [1:0] row_col_s;
    logic [3:0] row_key_s;
    logic [2:0] tot_sum_s;
    logic [1:0] tot_cnt_s;
    logic [3:0] tot_key_s;
    logic       slot_end_s;
    logic       scan_done_s;
    result_t    result_s;
    logic [3:0] count_inc_s;
    logic       deb_hit_s;
    logic [9:0] digit_s;

    // Key codes are row*3+col; * (9) and # (11) have no digit bit.
    function automatic logic [9:0] key_to_digit(input logic [3:0] key);
        logic [9:0] d;
        case (key)
            4'd0:    d = 10'b0000000010;
            4'd1:    d = 10'b0000000100;
            4'd2:    d = 10'b0000001000;
            4'd3:    d = 10'b0000010000;
            4'd4:    d = 10'b0000100000;
            4'd5:    d = 10'b0001000000;
            4'd6:    d = 10'b0010000000;
            4'd7:    d = 10'b0100000000;
            4'd8:    d = 10'b1000000000;
            4'd10:   d = 10'b0000000001;
            default: d = 10'b0000000000;
        endcase
        return d;
    endfunction

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta_q <= 3'b111;
            col_sync_q <= 3'b111;
        end else begin
            col_meta_q <= col_n;
            col_sync_q <= col_meta_q;
        end
    end

    // Free-running slot divider and row walker; never stalled by the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= 8'd0;
            row_q   <= 2'd0;
            row_n_q <= 4'b1110;
        end else if (slot_end_s) begin
            div_q   <= 8'd0;
            row_q   <= row_q + 2'd1;
            row_n_q <= {row_n_q[2:0], row_n_q[3]};
        end else begin
            div_q   <= div_q + 8'd1;
        end
    end

    // Per-row column decode merged into the running scan tally.
    always_comb begin
        row_low_s  = ~col_sync_q;
        row_hits_s = {1'b0, row_low_s[0]} + {1'b0, row_low_s[1]} + {1'b0, row_low_s[2]};
        if (row_low_s[0]) begin
            row_col_s = 2'd0;
        end else if (row_low_s[1]) begin
            row_col_s = 2'd1;
        end else if (row_low_s[2]) begin
            row_col_s = 2'd2;
        end else begin
            row_col_s = 2'd0;
        end
        row_key_s = ({2'b00, row_q} * 4'd3) + {2'b00, row_col_s};
        tot_sum_s = {1'b0, acc_cnt_q} + {1'b0, row_hits_s};
        if (tot_sum_s >= 3'd2) begin
            tot_cnt_s = 2'd2;
        end else begin
            tot_cnt_s = tot_sum_s[1:0];
        end
        if ((acc_cnt_q == 2'd0) && (row_hits_s == 2'd1)) begin
            tot_key_s = row_key_s;
        end else begin
            tot_key_s = acc_key_q;
        end
        case (tot_cnt_s)
            2'd0:    result_s = RES_NONE;
            2'd1:    result_s = RES_SINGLE;
            default: result_s = RES_MULTI;
        endcase
        slot_end_s  = (div_q == DIV_LAST);
        scan_done_s = slot_end_s && (row_q == 2'd3);
        count_inc_s = count_q + 4'd1;
        deb_hit_s   = (count_inc_s >= DEB_N);
        digit_s     = key_to_digit(tot_key_s);
    end

    // Scan tally: sampled on the last clock of each slot, restarted after row 3.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_cnt_q <= 2'd0;
            acc_key_q <= 4'd0;
        end else if (slot_end_s) begin
            if (row_q == 2'd3) begin
                acc_cnt_q <= 2'd0;
                acc_key_q <= 4'd0;
            end else begin
                acc_cnt_q <= tot_cnt_s;
                acc_key_q <= tot_key_s;
            end
        end else begin
            acc_cnt_q <= acc_cnt_q;
            acc_key_q <= acc_key_q;
        end
    end

    // Debounce FSM with registered strobe, digit and held outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cand_q   <= 4'd0;
            count_q  <= 4'd0;
            keypad_q <= 10'd0;
            valid_q  <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            keypad_q <= 10'd0;
            valid_q  <= 1'b0;
            if (scan_done_s) begin
                case (state_q)
                    IDLE: begin
                        if (result_s == RES_SINGLE) begin
                            cand_q <= tot_key_s;
                            if (deb_hit_s) begin
                                state_q  <= PRESSED;
                                count_q  <= 4'd0;
                                held_q   <= 1'b1;
                                keypad_q <= digit_s;
                                valid_q  <= |digit_s;
                            end else begin
                                state_q <= PRESS_DB;
                                count_q <= count_inc_s;
                            end
                        end else begin
                            count_q <= 4'd0;
                        end
                    end
                    PRESS_DB: begin
                        if ((result_s == RES_SINGLE) && (tot_key_s == cand_q)) begin
                            if (deb_hit_s) begin
                                state_q  <= PRESSED;
                                count_q  <= 4'd0;
                                held_q   <= 1'b1;
                                keypad_q <= digit_s;
                                valid_q  <= |digit_s;
                            end else begin
                                count_q <= count_inc_s;
                            end
                        end else begin
                            state_q <= IDLE;
                            count_q <= 4'd0;
                        end
                    end
                    PRESSED: begin
                        if (result_s == RES_NONE) begin
                            if (deb_hit_s) begin
                                state_q <= IDLE;
                                count_q <= 4'd0;
                                held_q  <= 1'b0;
                            end else begin
                                state_q <= RELEASE_DB;
                                count_q <= count_inc_s;
                            end
                        end else begin
                            count_q <= 4'd0;
                        end
                    end
                    RELEASE_DB: begin
                        if (result_s == RES_NONE) begin
                            if (deb_hit_s) begin
                                state_q <= IDLE;
                                count_q <= 4'd0;
                                held_q  <= 1'b0;
                            end else begin
                                count_q <= count_inc_s;
                            end
                        end else begin
                            state_q <= PRESSED;
                            count_q <= 4'd0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        count_q <= 4'd0;
                        held_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign row_n     = row_n_q;
    assign keypad    = keypad_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule
